pong_game_ctrl: RTL
===================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter X_MAX, default 6'd62, meaning the right-wall/right-paddle column.
REQ-002 SHALL have parameter WIN_SCORE, default 4'd7, meaning the points needed to win.
REQ-003 SHALL have parameter SERVE_WAIT, default 8'd60, meaning the frame ticks held in SERVE.
REQ-004 SHALL have parameter PERIOD_INIT, default 19'd5, meaning the ball step period after each serve.
REQ-005 SHALL have parameter PERIOD_MIN, default 19'd2, meaning the floor on the ball step period.
REQ-006 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1, meaning system clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have ports start (in, 1, game start request) and frame_tick (in, 1, one-cycle pulse per frame).
REQ-010 SHALL have ports ball_x (in, 6), ball_y (in, 5) and move_strobe (in, 1, ball steps this cycle).
REQ-011 SHALL have ports paddle_l_y and paddle_r_y (in, 5 each, top row of each 4-row paddle).
REQ-012 SHALL have ports ball_load (out, 1, reload ball start position), ball_enable (out, 1) and serve_right (out, 1).
REQ-013 SHALL have ports move_period (out, 19), score_l and score_r (out, 4 each), state (out, 3) and winner (out, 2: 01 left, 10 right).

Function
REQ-014 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, presented on state.
REQ-015 IDLE: on start=1 SHALL clear both scores, set serve_right=1 and enter SERVE.
REQ-016 On entering SERVE, ball_load SHALL be 1 for exactly one cycle and move_period SHALL return to PERIOD_INIT.
REQ-017 SERVE SHALL count frame_tick pulses and enter PLAY on the cycle after the SERVE_WAIT-th pulse.
REQ-018 ball_enable SHALL be 1 only in PLAY.
REQ-019 Hit test: ball_y is inside paddle P when paddle_P_y <= ball_y <= paddle_P_y+3, compared in 6 bits with no wrap.
REQ-020 In PLAY with move_strobe=1 and ball_x==1: a left hit SHALL remain in PLAY; otherwise the point SHALL go to right and the state SHALL move to POINT.
REQ-021 In PLAY with move_strobe=1 and ball_x==X_MAX: a right hit SHALL remain in PLAY; otherwise the point SHALL go to left and the state SHALL move to POINT.
REQ-022 Column checks SHALL be ignored when move_strobe=0.
REQ-023 POINT SHALL last one cycle and increment the scorer's score once.
REQ-024 From POINT the block SHALL go to OVER if the new score equals WIN_SCORE, else to SERVE.
REQ-025 In that SERVE, serve_right SHALL point toward the player who lost the point (right lost -> serve_right=1).
REQ-026 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-027 OVER SHALL set winner, hold the scores, and on start=1 clear the scores and winner and enter SERVE.
REQ-028 start SHALL be ignored in SERVE, PLAY and POINT.

Reset
REQ-029 When reset=1 at a clock edge, the block SHALL enter IDLE regardless of state.
REQ-030 Reset values: ball_load=0, ball_enable=0, serve_right=1, move_period=PERIOD_INIT, scores=0, winner=00, serve counter=0.
REQ-031 reset SHALL take priority over start and over a simultaneous move_strobe.

Configuration
REQ-032 With PONG_SPEEDUP_EN defined, each paddle hit SHALL decrement move_period by 1, saturating at PERIOD_MIN.
REQ-033 Without PONG_SPEEDUP_EN, move_period SHALL stay at PERIOD_INIT at all times.

Verification
REQ-034 Reset then start=1 -> state=1, one-cycle ball_load, serve_right=1; 60 frame_ticks later -> state=2, ball_enable=1.
REQ-035 PLAY, paddle_l_y=10, ball_x=1, ball_y=13, move_strobe -> stays PLAY, scores unchanged; with macro, move_period 5->4.
REQ-036 PLAY, paddle_l_y=10, ball_x=1, ball_y=14, move_strobe -> POINT, score_r +1, then SERVE with serve_right=0.
REQ-037 score_l=6, right miss at ball_x=62 -> score_l=7, state=4, winner=01; start -> scores 0, state=1.
REQ-038 Four hits with macro -> move_period 5,4,3,2,2; without macro stays 5.
REQ-039 reset=1 in the same cycle as a miss strobe -> IDLE, scores 0, no point awarded.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for a two-paddle pong.
// Walks IDLE -> SERVE -> PLAY -> POINT -> SERVE/OVER. It decides hits and misses
// at the paddle columns, keeps the two scores and the winner, and tells the
// ball datapath when to reload, when to move and which way to serve.
// Optional feature: define PONG_SPEEDUP_EN so that each paddle hit shortens the
// ball step period by one, down to PERIOD_MIN. Without the macro the period
// stays at PERIOD_INIT.

module pong_game_ctrl #(
    parameter logic [5:0]  X_MAX       = 6'd62,
    parameter logic [3:0]  WIN_SCORE   = 4'd7,
    parameter logic [7:0]  SERVE_WAIT  = 8'd60,
    parameter logic [18:0] PERIOD_INIT = 19'd5,
    parameter logic [18:0] PERIOD_MIN  = 19'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [5:0]  ball_x,
    input  logic [4:0]  ball_y,
    input  logic        move_strobe,
    input  logic [4:0]  paddle_l_y,
    input  logic [4:0]  paddle_r_y,
    output logic        ball_load,
    output logic        ball_enable,
    output logic        serve_right,
    output logic [18:0] move_period,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [2:0]  state,
    output logic [1:0]  winner
);

`ifdef PONG_SPEEDUP_EN
    localparam logic SPEEDUP_ON = 1'b1;
`else
    localparam logic SPEEDUP_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t      cur_state;
    state_t      next_state;
    logic [7:0]  serve_cnt;
    logic        point_right;
    logic        hit_l;
    logic        hit_r;
    logic        at_left;
    logic        at_right;
    logic        paddle_hit;
    logic        miss;
    logic [3:0]  score_l_inc;
    logic [3:0]  score_r_inc;
    logic [3:0]  scorer_next;
    logic        entering_serve;

    // Paddle hit tests, widened to 6 bits so a paddle near the bottom cannot wrap
    always_comb begin
        hit_l = ({1'b0, paddle_l_y} <= {1'b0, ball_y}) &&
                ({1'b0, ball_y} <= ({1'b0, paddle_l_y} + 6'd3));
        hit_r = ({1'b0, paddle_r_y} <= {1'b0, ball_y}) &&
                ({1'b0, ball_y} <= ({1'b0, paddle_r_y} + 6'd3));
    end

    // Column events only count in PLAY on a move strobe; the left column wins a tie
    always_comb begin
        at_left     = (cur_state == S_PLAY) && move_strobe && (ball_x == 6'd1);
        at_right    = (cur_state == S_PLAY) && move_strobe && (ball_x == X_MAX) && (ball_x != 6'd1);
        paddle_hit  = (at_left && hit_l) || (at_right && hit_r);
        miss        = (at_left && !hit_l) || (at_right && !hit_r);
        score_l_inc = (score_l < WIN_SCORE) ? (score_l + 4'd1) : score_l;
        score_r_inc = (score_r < WIN_SCORE) ? (score_r + 4'd1) : score_r;
        scorer_next = point_right ? score_r_inc : score_l_inc;
    end

    // Next-state decision for the game sequence
    always_comb begin
        next_state = cur_state;
        unique case (cur_state)
            S_IDLE:  if (start) next_state = S_SERVE;
            S_SERVE: if (frame_tick && (serve_cnt == (SERVE_WAIT - 8'd1))) next_state = S_PLAY;
            S_PLAY:  if (miss) next_state = S_POINT;
            S_POINT: next_state = (scorer_next == WIN_SCORE) ? S_OVER : S_SERVE;
            S_OVER:  if (start) next_state = S_SERVE;
            default: next_state = S_IDLE;
        endcase
    end

    assign entering_serve = (next_state == S_SERVE) && (cur_state != S_SERVE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_IDLE;
        else       cur_state <= next_state;
    end

    // One-cycle reload pulse and frame counting while waiting to serve
    always_ff @(posedge clk) begin
        if (reset) begin
            ball_load <= 1'b0;
            serve_cnt <= 8'd0;
        end else begin
            ball_load <= entering_serve;
            if (entering_serve)
                serve_cnt <= 8'd0;
            else if ((cur_state == S_SERVE) && frame_tick)
                serve_cnt <= serve_cnt + 8'd1;
        end
    end

    // Ball step period: restored on every serve, optionally shortened per hit
    always_ff @(posedge clk) begin
        if (reset)
            move_period <= PERIOD_INIT;
        else if (entering_serve)
            move_period <= PERIOD_INIT;
        else if (SPEEDUP_ON && paddle_hit && (move_period > PERIOD_MIN))
            move_period <= move_period - 19'd1;
    end

    // Scores, winner, serve direction and the side owed the pending point
    always_ff @(posedge clk) begin
        if (reset) begin
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            winner      <= 2'b00;
            serve_right <= 1'b1;
            point_right <= 1'b0;
        end else begin
            if (miss)
                point_right <= at_left;
            if (((cur_state == S_IDLE) || (cur_state == S_OVER)) && start) begin
                score_l     <= 4'd0;
                score_r     <= 4'd0;
                winner      <= 2'b00;
                serve_right <= 1'b1;
            end else if (cur_state == S_POINT) begin
                if (point_right) begin
                    score_r     <= score_r_inc;
                    serve_right <= 1'b0;
                end else begin
                    score_l     <= score_l_inc;
                    serve_right <= 1'b1;
                end
                if (next_state == S_OVER)
                    winner <= point_right ? 2'b10 : 2'b01;
            end
        end
    end

    assign ball_enable = (cur_state == S_PLAY);
    assign state       = cur_state;

endmodule
